fb_port_a_arbiter: RTL and testbench

Sequences and shares port A of the RGB display frame-buffer dual-port memory (the host-side read/write port; port B stays owned by the line renderer). It arbitrates between a host requester (req/ack bus) and a built-in frame-clear engine that fills the whole buffer with a constant word. It sits between the SoC bus glue and the `addr_a`/`data_in_a`/`wr_en`/`rd_en`/`dat_out_a` pins of the frame-buffer memory, in the same clock domain.

---
 rtl/fb_port_a_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_fb_port_a_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_a_arbiter.sv
// Port A arbiter for the RGB frame-buffer dual-port memory.
// Shares the host-side read/write port between a req/ack host and a
// frame-clear engine that fills every word with a latched constant.
// While a clear runs, host grants and clear writes alternate so the host
// never waits more than one extra cycle and each grant costs the clear one cycle.
module fb_port_a_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 2304
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_rvalid,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                clr_all_q;   // every clear write has been issued
    logic                last_host_q; // last port-A slot in CLEAR went to the host
    logic [DATA_W-1:0]   clr_val_q;

    logic                h_ack_q;
    logic                mem_we_q;
    logic                mem_re_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                clr_busy_q;
    logic                clr_done_q;

    logic                vld_p0_q;
    logic                zero_p0_q;
    logic                vld_p1_q;
    logic                zero_p1_q;
    logic                h_rvalid_q;
    logic [DATA_W-1:0]   h_rdata_q;

    logic                host_pend;
    logic                host_in_range;
    logic                cnt_at_last;
    logic                host_grant;
    logic                clr_write;

    // A request is only sampled while no ack is showing, capping the host at one grant per two cycles.
    assign host_pend     = h_req & ~h_ack_q;
    assign host_in_range = (h_addr <= LAST_ADDR);
    assign cnt_at_last   = (cnt_q == LAST_ADDR);

    // Decide who owns port A on the coming edge.
    always_comb begin
        host_grant = 1'b0;
        clr_write  = 1'b0;
        case (state_q)
            S_IDLE: begin
                host_grant = host_pend;
            end
            S_CLEAR: begin
                if (clr_all_q) begin
                    host_grant = host_pend;
                end else if (host_pend && !last_host_q) begin
                    host_grant = 1'b1;
                end else begin
                    clr_write = 1'b1;
                end
            end
            default: begin
                host_grant = 1'b0;
                clr_write  = 1'b0;
            end
        endcase
    end

    // Arbitration FSM, clear counter and registered memory/host/clear outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            clr_all_q   <= 1'b0;
            last_host_q <= 1'b1;
            clr_val_q   <= '0;
            h_ack_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            h_ack_q    <= host_grant;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            clr_done_q <= 1'b0;

            if (host_grant) begin
                // Out-of-range addresses are acked but never strobe the memory.
                mem_addr_q  <= h_addr;
                mem_wdata_q <= h_wdata;
                mem_we_q    <= h_we & host_in_range;
                mem_re_q    <= ~h_we & host_in_range;
                last_host_q <= 1'b1;
            end else if (clr_write) begin
                mem_addr_q  <= cnt_q;
                mem_wdata_q <= clr_val_q;
                mem_we_q    <= 1'b1;
                last_host_q <= 1'b0;
                if (cnt_at_last) begin
                    clr_all_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (clr_start) begin
                        state_q     <= S_CLEAR;
                        clr_val_q   <= clr_value;
                        cnt_q       <= '0;
                        clr_all_q   <= 1'b0;
                        clr_busy_q  <= 1'b1;
                        last_host_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_all_q) begin
                        state_q    <= S_IDLE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                        clr_all_q  <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Read-return pipeline: grant, memory access, then capture of mem_rdata.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            vld_p0_q   <= 1'b0;
            zero_p0_q  <= 1'b0;
            vld_p1_q   <= 1'b0;
            zero_p1_q  <= 1'b0;
            h_rvalid_q <= 1'b0;
            h_rdata_q  <= '0;
        end else begin
            // p0: read granted, memory strobe showing
            vld_p0_q  <= host_grant & ~h_we;
            zero_p0_q <= ~host_in_range;
            // p1: memory output register now holds the word
            vld_p1_q  <= vld_p0_q;
            zero_p1_q <= zero_p0_q;
            // p2: word returned to the host
            h_rvalid_q <= vld_p1_q;
            h_rdata_q  <= (vld_p1_q && !zero_p1_q) ? mem_rdata : '0;
        end
    end

    assign h_ack     = h_ack_q;
    assign h_rdata   = h_rdata_q;
    assign h_rvalid  = h_rvalid_q;
    assign clr_busy  = clr_busy_q;
    assign clr_done  = clr_done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_fb_port_a_arbiter.sv
// Bench for fb_port_a_arbiter: frame-buffer memory model, transaction-level
// reference model, per-cycle compare process and directed/random stimulus.
module tb_fb_port_a_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 2304;

    logic              i_clk     = 1'b0;
    logic              i_rst     = 1'b0;
    logic              h_req     = 1'b0;
    logic              h_we      = 1'b0;
    logic [ADDR_W-1:0] h_addr    = '0;
    logic [DATA_W-1:0] h_wdata   = '0;
    logic              clr_start = 1'b0;
    logic [DATA_W-1:0] clr_value = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              h_ack;
    logic [DATA_W-1:0] h_rdata;
    logic              h_rvalid;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;

    int n_vec = 0;
    int n_err = 0;

    fb_port_a_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Frame-buffer port A: synchronous write, registered read.
    logic [DATA_W-1:0] fb_mem [DEPTH];
    always @(posedge i_clk) begin
        if (mem_we && mem_addr < ADDR_W'(DEPTH)) fb_mem[mem_addr] <= mem_wdata;
        if (mem_re && mem_addr < ADDR_W'(DEPTH)) mem_rdata <= fb_mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int                cyc = 0;
    bit                m_busy = 1'b0;
    int                m_left = 0;
    int                m_next = 0;
    bit                m_last_host = 1'b1;
    logic [DATA_W-1:0] m_clrval = '0;
    bit                e_ack = 1'b0, e_we = 1'b0, e_re = 1'b0;
    bit                e_busy = 1'b0, e_done = 1'b0, e_rvalid = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_wdata = '0, e_rdata = '0;
    logic [DATA_W-1:0] shadow [DEPTH];
    bit                pw_v = 1'b0;
    logic [ADDR_W-1:0] pw_a = '0;
    logic [DATA_W-1:0] pw_d = '0;
    int                rq_due[$];
    logic [DATA_W-1:0] rq_dat[$];

    task automatic model_reset();
        m_busy = 1'b0; m_left = 0; m_next = 0; m_last_host = 1'b1;
        e_ack = 1'b0; e_we = 1'b0; e_re = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rvalid = 1'b0;
        pw_v = 1'b0;
        rq_due.delete();
        rq_dat.delete();
    endtask

    task automatic model_step();
        bit pend;
        bit grant;
        bit in_rng;
        cyc++;
        // a write issued last cycle lands in memory on this edge
        if (pw_v) shadow[pw_a] = pw_d;
        pw_v   = 1'b0;
        pend   = h_req && !e_ack;
        grant  = 1'b0;
        e_we   = 1'b0;
        e_re   = 1'b0;
        e_done = 1'b0;
        if (!m_busy) begin
            grant = pend;
            if (clr_start) begin
                m_busy = 1'b1; m_left = DEPTH; m_next = 0;
                m_clrval = clr_value; m_last_host = 1'b1;
            end
        end else if (m_left == 0) begin
            grant  = pend;
            m_busy = 1'b0;
            e_done = 1'b1;
        end else if (pend && !m_last_host) begin
            grant = 1'b1;
        end else begin
            e_we = 1'b1; e_addr = ADDR_W'(m_next); e_wdata = m_clrval;
            pw_v = 1'b1; pw_a = ADDR_W'(m_next); pw_d = m_clrval;
            m_next++; m_left--; m_last_host = 1'b0;
        end
        e_ack = grant;
        if (grant) begin
            in_rng = (int'(h_addr) < DEPTH);
            m_last_host = 1'b1;
            e_addr  = h_addr;
            e_wdata = h_wdata;
            if (h_we && in_rng) begin
                e_we = 1'b1; pw_v = 1'b1; pw_a = h_addr; pw_d = h_wdata;
            end
            if (!h_we) begin
                e_re = in_rng;
                rq_due.push_back(cyc + 2);
                rq_dat.push_back(in_rng ? shadow[h_addr] : '0);
            end
        end
        e_busy   = m_busy;
        e_rvalid = 1'b0;
        if (rq_due.size() > 0 && rq_due[0] == cyc) begin
            e_rvalid = 1'b1;
            e_rdata  = rq_dat.pop_front();
            void'(rq_due.pop_front());
        end
    endtask

    initial forever begin
        @(posedge i_clk or negedge i_rst);
        if (!i_rst) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge i_clk);
        chk("ack", 32'(h_ack), 32'(e_ack));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_re", 32'(mem_re), 32'(e_re));
        chk("clr_busy", 32'(clr_busy), 32'(e_busy));
        chk("clr_done", 32'(clr_done), 32'(e_done));
        chk("h_rvalid", 32'(h_rvalid), 32'(e_rvalid));
        if (e_ack || e_we) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        if (e_rvalid) chk("h_rdata", 32'(h_rdata), 32'(e_rdata));
        chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic new_op(input int lo, input int hi);
        h_req = 1'b1;
        h_we  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) h_addr = ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1));
        else h_addr = ADDR_W'($urandom_range(lo, hi));
        h_wdata = DATA_W'($urandom);
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output bit ok);
        int n;
        ok = 1'b0;
        d  = '0;
        h_req = 1'b1; h_we = 1'b0; h_addr = a;
        n = 0;
        do begin @(negedge i_clk); n++; end while (!h_ack && n < 8);
        h_req = 1'b0;
        if (!h_ack) return;
        n = 0;
        do begin @(negedge i_clk); n++; end while (!h_rvalid && n < 4);
        if (h_rvalid) begin ok = 1'b1; d = h_rdata; end
    endtask

    function automatic logic all_out_or();
        return |{h_ack, h_rdata, h_rvalid, clr_busy, clr_done, mem_addr, mem_wdata, mem_we, mem_re};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int j, done_j, grants, wr_cnt, bad, seen_done, seen_rv;
        bit ok;
        logic [DATA_W-1:0] d;

        // reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            chk("reset_all_zero", 32'(all_out_or()), 32'd0);
            h_req = 1'($urandom_range(0, 1)); h_we = 1'($urandom_range(0, 1));
            h_addr = ADDR_W'($urandom); h_wdata = DATA_W'($urandom);
            clr_start = 1'($urandom_range(0, 1)); clr_value = DATA_W'($urandom);
        end
        h_req = 1'b0; clr_start = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("post_reset_quiet", 32'(mem_we | mem_re | h_ack), 32'd0);

        // host write then read in IDLE
        h_req = 1'b1; h_we = 1'b1; h_addr = 12'h010; h_wdata = 24'hABC123;
        @(negedge i_clk);
        chk("wr_ack", 32'(h_ack), 32'd1);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'h010);
        h_req = 1'b0;
        @(negedge i_clk);
        h_req = 1'b1; h_we = 1'b0; h_addr = 12'h010;
        @(negedge i_clk);
        chk("rd_ack", 32'(h_ack), 32'd1);
        chk("rd_re", 32'(mem_re), 32'd1);
        h_req = 1'b0;
        @(negedge i_clk);
        chk("rd_rvalid_early", 32'(h_rvalid), 32'd0);
        @(negedge i_clk);
        chk("rd_rvalid", 32'(h_rvalid), 32'd1);
        chk("rd_data", 32'(h_rdata), 32'hABC123);

        // out-of-range write and read at DEPTH
        h_req = 1'b1; h_we = 1'b1; h_addr = 12'd2304; h_wdata = 24'h777777;
        @(negedge i_clk);
        chk("oor_wr_ack", 32'(h_ack), 32'd1);
        chk("oor_wr_nostrobe", 32'(mem_we | mem_re), 32'd0);
        h_req = 1'b0;
        @(negedge i_clk);
        h_req = 1'b1; h_we = 1'b0; h_addr = 12'd2304;
        @(negedge i_clk);
        chk("oor_rd_ack", 32'(h_ack), 32'd1);
        chk("oor_rd_nostrobe", 32'(mem_we | mem_re), 32'd0);
        h_req = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("oor_rd_rvalid", 32'(h_rvalid), 32'd1);
        chk("oor_rd_data", 32'(h_rdata), 32'd0);

        // uncontended clear with an ignored second start
        clr_value = 24'h000FFF; clr_start = 1'b1;
        @(negedge i_clk);
        clr_start = 1'b0;
        chk("clr_busy_set", 32'(clr_busy), 32'd1);
        j = 0; wr_cnt = 0; bad = 0; done_j = -1;
        while (done_j < 0 && j < 3000) begin
            @(negedge i_clk);
            j++;
            if (mem_we) begin
                if (int'(mem_addr) != wr_cnt || mem_wdata != 24'h000FFF) bad++;
                wr_cnt++;
            end
            if (clr_done) done_j = j;
            clr_start = (j == 100);
            clr_value = (j == 100) ? 24'h123456 : 24'h000FFF;
        end
        clr_start = 1'b0;
        chk("clr_write_count", 32'(wr_cnt), 32'd2304);
        chk("clr_write_order", 32'(bad), 32'd0);
        chk("clr_done_cycle", 32'(done_j), 32'd2305);
        chk("clr_busy_cleared", 32'(clr_busy), 32'd0);
        host_read(12'd2303, d, ok);
        chk("clr_rd_last_ok", 32'(ok), 32'd1);
        chk("clr_rd_last", 32'(d), 32'h000FFF);
        host_read(12'h010, d, ok);
        chk("clr_rd_010", 32'(d), 32'h000FFF);

        // clear against a continuously requesting host
        @(negedge i_clk);
        clr_value = 24'h3C3C3C; clr_start = 1'b1;
        @(negedge i_clk);
        clr_start = 1'b0;
        new_op(1024, DEPTH - 1);
        j = 0; grants = 0; done_j = -1;
        while (done_j < 0 && j < 6000) begin
            @(negedge i_clk);
            j++;
            if (clr_done) done_j = j;
            else if (h_ack) grants++;
            if (h_ack) new_op(1024, DEPTH - 1);
        end
        h_req = 1'b0;
        chk("contended_grants", 32'(grants), 32'd2303);
        chk("contended_done_delay", 32'(done_j), 32'(2305 + grants));
        @(negedge i_clk);
        host_read(12'd5, d, ok);
        chk("contended_rd_5", 32'(d), 32'h3C3C3C);

        // simultaneous host request and clear start, then reset mid-clear
        @(negedge i_clk);
        h_req = 1'b1; h_we = 1'b1; h_addr = 12'h020; h_wdata = 24'h13579B;
        clr_start = 1'b1; clr_value = 24'h555AAA;
        @(negedge i_clk);
        chk("sim_ack", 32'(h_ack), 32'd1);
        chk("sim_host_addr", 32'(mem_addr), 32'h020);
        chk("sim_busy", 32'(clr_busy), 32'd1);
        h_req = 1'b0; clr_start = 1'b0;
        @(negedge i_clk);
        chk("sim_clr_we", 32'(mem_we), 32'd1);
        chk("sim_clr_addr", 32'(mem_addr), 32'd0);
        chk("sim_clr_wdata", 32'(mem_wdata), 32'h555AAA);
        j = 0;
        while (!(mem_we && mem_addr == 12'd1000) && j < 1100) begin
            @(negedge i_clk);
            j++;
        end
        chk("sim_reach_1000", 32'(mem_we && mem_addr == 12'd1000), 32'd1);
        #2 i_rst = 1'b0;
        #1 chk("abort_all_zero", 32'(all_out_or()), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (clr_done || clr_busy) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);

        // reset while a read is in flight
        h_req = 1'b1; h_we = 1'b0; h_addr = 12'h010;
        @(negedge i_clk);
        chk("abort_rd_ack", 32'(h_ack), 32'd1);
        h_req = 1'b0;
        #2 i_rst = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        seen_rv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            if (h_rvalid) seen_rv++;
        end
        chk("abort_no_rvalid", 32'(seen_rv), 32'd0);

        // randomized traffic with occasional clears
        for (int i = 0; i < 12000; i++) begin
            @(negedge i_clk);
            clr_start = ($urandom_range(0, 2999) == 0);
            clr_value = DATA_W'($urandom);
            if (h_req && h_ack) begin
                if ($urandom_range(0, 1) == 1) new_op(0, DEPTH - 1);
                else h_req = 1'b0;
            end else if (!h_req && $urandom_range(0, 2) == 0) begin
                new_op(0, DEPTH - 1);
            end
        end
        h_req = 1'b0; clr_start = 1'b0;
        repeat (4) @(negedge i_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
